icache_fetch: RTL and testbench

//  Direct-mapped instruction cache between the IF stage and the shared off-chip memory port.

---
 rtl/icache_fetch_pkg.sv | 28 ++
 rtl/icache_data_array.sv | 31 +++
 rtl/icache_fetch.sv | 179 +++++++++++++++++
 tb/tb_icache_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_fetch_pkg.sv
// Shared types and geometry helpers for the instruction cache.
package icache_fetch_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned LINE_WORDS_DEF = 4;
  localparam int unsigned NUM_LINES_DEF = 16;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StFill,
    StDone
  } state_e;

  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned line_words,
                                        input int unsigned num_lines);
    return WORD_W - $clog2(num_lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Line data storage: one synchronous write port, one combinational read port.
module icache_data_array
  import icache_fetch_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned NUM_LINES  = NUM_LINES_DEF,
  localparam int unsigned OFF_W     = off_w(LINE_WORDS),
  localparam int unsigned IDX_W     = idx_w(NUM_LINES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_word,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem_q [NUM_LINES][LINE_WORDS];

  // Fill beats write one word; contents need no reset because valid bits gate every read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_idx][wr_word] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx][rd_off];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache: same-cycle hits, whole-line fill on a miss.
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned NUM_LINES  = NUM_LINES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc,
  input  logic              rd_en,
  input  logic              inv,
  output logic [WORD_W-1:0] instr,
  output logic              instr_vld,
  output logic              stall,
  output logic              mem_req,
  output logic [15:0]       mem_addr,
  input  logic              mem_rdy,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int unsigned OFF_W = off_w(LINE_WORDS);
  localparam int unsigned IDX_W = idx_w(NUM_LINES);
  localparam int unsigned TAG_W = tag_w(LINE_WORDS, NUM_LINES);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  state_e                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q [NUM_LINES];
  logic [15:OFF_W]        laddr_q, laddr_d;
  logic [OFF_W-1:0]       beat_q, beat_d;
  logic                   inv_pend_q, inv_pend_d;
  logic [15:0]            hit_cnt_q, hit_cnt_d;
  logic [15:0]            miss_cnt_q, miss_cnt_d;

  logic [OFF_W-1:0]       off;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic [IDX_W-1:0]       lidx;
  logic [TAG_W-1:0]       ltag;
  logic                   hit;
  logic                   data_we;
  logic                   tag_we;
  logic                   miss_accept;
  logic [WORD_W-1:0]      rd_data;

  assign off  = pc[OFF_W-1:0];
  assign idx  = pc[OFF_W+IDX_W-1:OFF_W];
  assign tag  = pc[15:OFF_W+IDX_W];
  assign lidx = laddr_q[OFF_W+IDX_W-1:OFF_W];
  assign ltag = laddr_q[15:OFF_W+IDX_W];

  assign hit = rd_en && valid_q[idx] && (tag_q[idx] == tag) && (state_q == StIdle);

  assign instr     = hit ? rd_data : '0;
  assign instr_vld = hit;
  assign mem_addr  = {laddr_q, {OFF_W{1'b0}}};
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  icache_data_array #(
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES)
  ) u_data (
    .clk     (clk),
    .we      (data_we),
    .wr_idx  (lidx),
    .wr_word (beat_q),
    .wr_data (mem_rdata),
    .rd_idx  (idx),
    .rd_off  (off),
    .rd_data (rd_data)
  );

  // Miss FSM: next state, fill control, valid bookkeeping and stall/request outputs.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    laddr_d     = laddr_q;
    beat_d      = beat_q;
    inv_pend_d  = inv_pend_q;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    stall       = 1'b0;
    mem_req     = 1'b0;
    miss_accept = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rd_en && !hit) begin
          stall   = 1'b1;
          laddr_d = pc[15:OFF_W];
          state_d = StReq;
        end
      end
      StReq: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_rdy) begin
          miss_accept = 1'b1;
          beat_d      = '0;
          state_d     = StFill;
        end
      end
      StFill: begin
        stall = 1'b1;
        if (inv) begin
          inv_pend_d = 1'b1;
        end
        if (mem_rvalid) begin
          data_we = 1'b1;
          beat_d  = beat_q + OFF_W'(1);
          if (beat_q == LAST_BEAT) begin
            tag_we  = 1'b1;
            // An invalidate seen anywhere in this fill leaves the line invalid.
            if (!inv_pend_q && !inv) begin
              valid_d[lidx] = 1'b1;
            end
            state_d = StDone;
          end
        end
      end
      StDone: begin
        stall      = 1'b1;
        inv_pend_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (inv) begin
      valid_d = '0;
    end
  end

  // Saturating performance counters.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
    if (miss_accept && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      laddr_q    <= '0;
      beat_q     <= '0;
      inv_pend_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      laddr_q    <= laddr_d;
      beat_q     <= beat_d;
      inv_pend_q <= inv_pend_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag array; written with the last fill beat, meaningless while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[lidx] <= ltag;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch with a simple fixed-latency memory model.
module tb_icache_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        rd_en;
  logic        inv;
  logic [15:0] instr;
  logic        instr_vld;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rdy;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model state.
  int          beats_left = 0;
  int          beat_i     = 0;
  logic [15:0] base       = '0;
  logic [15:0] last_addr  = '0;
  int          acc_cnt    = 0;

  icache_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .rd_en      (rd_en),
    .inv        (inv),
    .instr      (instr),
    .instr_vld  (instr_vld),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdy    (mem_rdy),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accept when req&rdy; stream 4 beats of 0xA000+addr starting the cycle after accept.
  // Beats keep flowing after a reset so that stray beats reach the DUT.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (beats_left > 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hA000 + base + 16'(beat_i);
        beat_i++;
        beats_left--;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
      if (mem_req && mem_rdy) begin
        base       = mem_addr;
        last_addr  = mem_addr;
        acc_cnt++;
        beats_left = 4;
        beat_i     = 0;
      end
    end
  end

  // Present a fetch and count stall cycles until the hit; 40 cycles is the timeout.
  task automatic fetch(input logic [15:0] a, output logic [15:0] d, output int stalls);
    @(negedge clk);
    pc     = a;
    rd_en  = 1'b1;
    inv    = 1'b0;
    #1;
    stalls = 0;
    while (!instr_vld && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    d = instr;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    rd_en = 1'b0;
    inv   = 1'b0;
    #1;
  endtask

  logic [15:0] d;
  int          s;
  int          acc0;

  initial begin
    rst     = 1'b1;
    pc      = '0;
    rd_en   = 1'b0;
    inv     = 1'b0;
    mem_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", stall, 0);
    check("rst_vld", instr_vld, 0);
    check("rst_instr", instr, 0);
    check("rst_req", mem_req, 0);
    check("rst_hits", hit_cnt, 0);
    check("rst_misses", miss_cnt, 0);

    // 1: cold miss on line 0, then four hits.
    @(negedge clk);
    pc    = 16'h0000;
    rd_en = 1'b1;
    #1;
    check("t1_miss_stall_comb", stall, 1);
    fetch(16'h0000, d, s);
    check("t1_stalls", s, 6);
    check("t1_w0", d, 16'hA000);
    check("t1_addr", last_addr, 16'h0000);
    fetch(16'h0001, d, s);
    check("t1_w1", d, 16'hA001);
    check("t1_w1_stalls", s, 0);
    fetch(16'h0002, d, s);
    check("t1_w2", d, 16'hA002);
    fetch(16'h0003, d, s);
    check("t1_w3", d, 16'hA003);
    check("t1_w3_stall", stall, 0);
    idle_cycle();
    check("t1_idle_vld", instr_vld, 0);
    check("t1_idle_stall", stall, 0);
    check("t1_hits", hit_cnt, 4);
    check("t1_misses", miss_cnt, 1);

    // 2: conflict misses on index 0.
    fetch(16'h0040, d, s);
    check("t2_b_stalls", s, 7);
    check("t2_b_data", d, 16'hA040);
    check("t2_b_addr", last_addr, 16'h0040);
    fetch(16'h0000, d, s);
    check("t2_a_stalls", s, 7);
    check("t2_a_data", d, 16'hA000);
    idle_cycle();
    check("t2_misses", miss_cnt, 3);

    // 3: memory not ready for 5 cycles.
    acc0 = acc_cnt;
    @(negedge clk);
    mem_rdy = 1'b0;
    pc      = 16'h0080;
    rd_en   = 1'b1;
    #1;
    check("t3_stall0", stall, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("t3_req", mem_req, 1);
      check("t3_addr", mem_addr, 16'h0080);
      check("t3_stall", stall, 1);
    end
    check("t3_no_accept", acc_cnt - acc0, 0);
    @(negedge clk);
    mem_rdy = 1'b1;
    fetch(16'h0080, d, s);
    check("t3_stalls", s, 5);
    check("t3_data", d, 16'hA080);

    // 4: pc redirect during the fill of line 0x0010.
    @(negedge clk);
    pc    = 16'h0010;
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    pc = 16'h0123;
    #1;
    check("t4_first_addr", last_addr, 16'h0010);
    fetch(16'h0123, d, s);
    check("t4_stalls", s, 10);
    check("t4_new_addr", last_addr, 16'h0120);
    check("t4_new_data", d, 16'hA123);
    fetch(16'h0010, d, s);
    check("t4_old_hit", s, 0);
    check("t4_old_data", d, 16'hA010);

    // 5: invalidate on the second fill beat.
    acc0 = acc_cnt;
    @(negedge clk);
    pc    = 16'h0030;
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    inv = 1'b1;
    fetch(16'h0030, d, s);
    check("t5_refetch_stalls", s, 10);
    check("t5_two_reqs", acc_cnt - acc0, 2);
    check("t5_data", d, 16'hA030);
    fetch(16'h0010, d, s);
    check("t5_other_cleared", s, 7);
    // inv coincident with a hit still returns the hit.
    @(negedge clk);
    pc    = 16'h0030;
    rd_en = 1'b1;
    inv   = 1'b1;
    #1;
    check("t5_inv_hit_vld", instr_vld, 1);
    check("t5_inv_hit_data", instr, 16'hA030);
    fetch(16'h0030, d, s);
    check("t5_after_inv_stalls", s, 7);

    // 6: reset mid-fill, then two stray beats.
    @(negedge clk);
    pc    = 16'h0050;
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst   = 1'b1;
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t6_stall", stall, 0);
      check("t6_req", mem_req, 0);
      check("t6_vld", instr_vld, 0);
      check("t6_hits", hit_cnt, 0);
      check("t6_misses", miss_cnt, 0);
      @(negedge clk);
    end
    fetch(16'h0030, d, s);
    check("t6_refill_stalls", s, 7);
    check("t6_refill_data", d, 16'hA030);
    fetch(16'h0050, d, s);
    check("t6_stray_line_stalls", s, 7);
    check("t6_stray_line_data", d, 16'hA050);
    idle_cycle();
    check("t6_misses_after", miss_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
